dsp_sub_i8_4_pipe: RTL
======================

DSP_SUB_I8_4_PIPE -- requirements
Module: dsp_sub_i8_4_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, number of i8 lanes; fixed, other values unsupported.
REQ-002 SHALL have parameter WIDTH, default 8, lane width in bits; fixed.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand set a_*/b_* valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have ports a_0..a_3  input  8 each  signed minuend lanes.
REQ-008 SHALL have ports b_0..b_3  input  8 each  signed subtrahend lanes.
REQ-009 SHALL have port out_valid  output  1  y_*/ovf valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have ports y_0..y_3  output  8 each  signed difference lanes.
REQ-012 SHALL have port ovf  output  4  per-lane signed overflow flag, bit i = lane i.

Function
REQ-013 SHALL compute y_i = a_i - b_i per lane, signed, lanes fully independent (no borrow crosses a lane).
REQ-014 SHALL pack lane i into 12-bit slot bits [12i+11:12i] of a 48-bit word, operands sign-extended to 12 bits.
REQ-015 SHALL set ovf[i] = slot bit 8 XOR slot bit 7 of the 12-bit lane difference (result outside -128..127).
REQ-016 SHALL, without saturation, output y_i = slot bits [7:0] (two's-complement wrap).
REQ-017 SHALL be a two-stage elastic pipeline: S1 operand register (A/B/C-reg equivalent), S2 result register (P-reg equivalent).
REQ-018 SHALL have latency exactly 2 cycles from accepted input (in_valid && in_ready) to out_valid with out_ready held high.
REQ-019 SHALL sustain throughput of one result per cycle while out_ready is high.
REQ-020 SHALL transfer on a stage only when its valid and downstream ready are both high; in_ready = !S1.valid || S1 advances this cycle.
REQ-021 SHALL hold y_*, ovf and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL, on simultaneous S2 drain and S1 advance, replace S2 contents in the same cycle without a bubble.
REQ-023 SHALL, when both stages are full and out_ready is low, deassert in_ready and drop no data.
REQ-024 SHALL ignore a_*/b_* whenever in_valid is low or in_ready is low.

Reset
REQ-025 SHALL, while reset is low at a clock edge, clear S1/S2 valid bits, all data registers, y_* = 0, ovf = 0, out_valid = 0.
REQ-026 SHALL drive in_ready = 1 in the first cycle after reset deasserts.
REQ-027 SHALL discard any in-flight operands on reset mid-operation; no result for them appears after reset.

Configuration
REQ-028 SHALL support macro DSP_SUB_SAT_EN; when defined, a lane with ovf[i] = 1 outputs 127 if the 12-bit difference is positive, else -128.
REQ-029 SHALL, without DSP_SUB_SAT_EN, wrap per REQ-016; ovf, latency and handshake are identical in both builds.

Structure
REQ-030 SHALL place LANE_W = 8, SLOT_W = 12, LANES = 4, a 48-bit packed-word typedef and lane pack/unpack functions in shared package dsp_simd_pkg.
REQ-031 SHALL implement each stage with one sub-module dsp_pipe_reg (valid/ready register slice, data-width parameter), instantiated twice.

Verification
REQ-032 Bench SHALL cover: a = {10,20,30,40}, b = {3,25,-5,40}, out_ready = 1 -> y = {7,-5,35,0}, ovf = 0000, out_valid exactly 2 cycles after accept.
REQ-033 Bench SHALL cover: a_0 = 127, b_0 = -1; a_1 = -128, b_1 = 1 -> ovf = 0011; y_0 = -128, y_1 = 127 (wrap) or y_0 = 127, y_1 = -128 with DSP_SUB_SAT_EN.
REQ-034 Bench SHALL cover: 8 back-to-back inputs, out_ready = 1 -> 8 results on 8 consecutive cycles, in order, in_ready never low.
REQ-035 Bench SHALL cover: out_ready = 0 for 5 cycles with in_valid = 1 -> exactly 2 accepts, in_ready low thereafter, outputs stable; on release, results in order, none lost or duplicated.
REQ-036 Bench SHALL cover: reset low for 1 cycle with both stages full -> next cycle out_valid = 0, y_* = 0, ovf = 0, in_ready = 1; no stale result ever emitted.
REQ-037 Bench SHALL cover: random a/b, random in_valid/out_ready for 10000 cycles -> scoreboard match against reference model, both configurations.

Source files
------------

// File: rtl/dsp_simd_pkg.sv
// Shared SIMD lane geometry: 4 x i8 lanes carried in 12-bit slots of a 48-bit word.
// Pack/unpack helpers plus the per-slot subtract used by the pipeline datapath.
package dsp_simd_pkg;

  localparam int LANE_W = 8;
  localparam int SLOT_W = 12;
  localparam int LANES  = 4;
  localparam int WORD_W = LANES * SLOT_W;

  typedef logic [LANE_W-1:0]               lane_t;
  typedef logic [LANES-1:0][LANE_W-1:0]    lanes_t;
  typedef logic [LANES-1:0][SLOT_W-1:0]    word_t;

  typedef struct packed {
    word_t a;
    word_t b;
  } opnd_t;

  typedef struct packed {
    logic [LANES-1:0] ovf;
    lanes_t           y;
  } rslt_t;

  function automatic word_t pack_lanes(input lanes_t v);
    word_t w;
    for (int i = 0; i < LANES; i++) begin
      w[i] = {{(SLOT_W-LANE_W){v[i][LANE_W-1]}}, v[i]};
    end
    return w;
  endfunction

  function automatic lanes_t unpack_lanes(input word_t w);
    lanes_t v;
    for (int i = 0; i < LANES; i++) begin
      v[i] = w[i][LANE_W-1:0];
    end
    return v;
  endfunction

  // Returns {ovf, y}. Slot headroom keeps the borrow inside the slot, so bit 8
  // disagreeing with bit 7 is exactly "result left the i8 range".
  function automatic logic [LANE_W:0] slot_sub(input logic [SLOT_W-1:0] a,
                                               input logic [SLOT_W-1:0] b,
                                               input logic              sat);
    logic [SLOT_W-1:0] d;
    logic              ov;
    lane_t             y;
    d  = a - b;
    ov = d[LANE_W] ^ d[LANE_W-1];
    y  = d[LANE_W-1:0];
    if (sat && ov) begin
      y = d[SLOT_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    end
    return {ov, y};
  endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// Elastic valid/ready register slice of parameterised data width.
// Latency: 1 cycle. Backpressure: accepts when empty or when draining this cycle; holds data while stalled.
module dsp_pipe_reg #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          up_vld,
  output logic          up_rdy,
  input  logic [DW-1:0] up_dat,
  output logic          dn_vld,
  input  logic          dn_rdy,
  output logic [DW-1:0] dn_dat
);

  assign up_rdy = !dn_vld || dn_rdy;

  always_ff @(posedge clock) begin
    if (!reset) begin
      dn_vld <= 1'b0;
      dn_dat <= '0;
    end else if (up_rdy) begin
      dn_vld <= up_vld;
      if (up_vld) begin
        dn_dat <= up_dat;
      end
    end
  end

endmodule

// File: rtl/dsp_sub_i8_4_pipe.sv
// 4-lane signed i8 subtract with per-lane overflow; DSP_SUB_SAT_EN selects saturation over wrap.
// Latency: 2 cycles (operand reg, result reg), one result per cycle.
// Backpressure: elastic valid/ready; in_ready drops only when both stages are full and out_ready is low.
module dsp_sub_i8_4_pipe #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a_0,
  input  logic signed [WIDTH-1:0] a_1,
  input  logic signed [WIDTH-1:0] a_2,
  input  logic signed [WIDTH-1:0] a_3,
  input  logic signed [WIDTH-1:0] b_0,
  input  logic signed [WIDTH-1:0] b_1,
  input  logic signed [WIDTH-1:0] b_2,
  input  logic signed [WIDTH-1:0] b_3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] y_0,
  output logic signed [WIDTH-1:0] y_1,
  output logic signed [WIDTH-1:0] y_2,
  output logic signed [WIDTH-1:0] y_3,
  output logic [LANES-1:0]        ovf
);

  import dsp_simd_pkg::*;

`ifdef DSP_SUB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  opnd_t s1_in_dat;
  opnd_t s1_dat;
  rslt_t s2_in_dat;
  rslt_t s2_dat;
  logic  s1_vld;
  logic  s1_rdy;

  assign s1_in_dat.a = pack_lanes({a_3, a_2, a_1, a_0});
  assign s1_in_dat.b = pack_lanes({b_3, b_2, b_1, b_0});

  dsp_pipe_reg #(.DW($bits(opnd_t))) u_s1 (
    .clock  (clock),
    .reset  (reset),
    .up_vld (in_valid),
    .up_rdy (in_ready),
    .up_dat (s1_in_dat),
    .dn_vld (s1_vld),
    .dn_rdy (s1_rdy),
    .dn_dat (s1_dat)
  );

  // Each lane subtracts in its own slot; no borrow path between slots.
  always_comb begin
    s2_in_dat = '0;
    for (int i = 0; i < LANES; i++) begin
      {s2_in_dat.ovf[i], s2_in_dat.y[i]} = slot_sub(s1_dat.a[i], s1_dat.b[i], SAT_EN);
    end
  end

  dsp_pipe_reg #(.DW($bits(rslt_t))) u_s2 (
    .clock  (clock),
    .reset  (reset),
    .up_vld (s1_vld),
    .up_rdy (s1_rdy),
    .up_dat (s2_in_dat),
    .dn_vld (out_valid),
    .dn_rdy (out_ready),
    .dn_dat (s2_dat)
  );

  assign y_0 = s2_dat.y[0];
  assign y_1 = s2_dat.y[1];
  assign y_2 = s2_dat.y[2];
  assign y_3 = s2_dat.y[3];
  assign ovf = s2_dat.ovf;

endmodule
